// File: rtl/approx_adder_pkg.sv
// Shared constants and the lower-part OR cell for the pipelined approximate adder.
package approx_adder_pkg;

    localparam logic MODE_APPROX = 1'b0;
    localparam logic MODE_EXACT  = 1'b1;

    localparam int unsigned STATS_SUM_W = 32;
    localparam int unsigned STATS_CNT_W = 16;

    function automatic logic loa_cell(input logic a, input logic b);
        return a | b;
    endfunction

endpackage

// File: rtl/approx_adder_segment.sv
// Combinational W-bit ripple segment; bits flagged in approx_i use the OR cell and
// generate a&b as the carry into the following bit.
module approx_adder_segment
    import approx_adder_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] approx_i,
    input  logic         carry_i,
    output logic [W-1:0] sum_o,
    output logic         carry_o
);

    logic [W:0] c;

    always_comb begin
        c     = '0;
        sum_o = '0;
        c[0]  = carry_i;
        for (int j = 0; j < int'(W); j++) begin
            if (approx_i[j]) begin
                sum_o[j] = loa_cell(a_i[j], b_i[j]);
                c[j+1]   = a_i[j] & b_i[j];
            end else begin
                sum_o[j] = a_i[j] ^ b_i[j] ^ c[j];
                c[j+1]   = (a_i[j] & b_i[j]) | (c[j] & (a_i[j] ^ b_i[j]));
            end
        end
    end

    assign carry_o = c[W];

endmodule

// File: rtl/approx_pipe_adder.sv
// Pipelined approximate adder with valid/ready flow control, one segment per stage.
// Define APPROX_ERR_STATS_EN to add the exact shadow adder and error statistics.
module approx_pipe_adder
    import approx_adder_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned APPROX_BITS = 2,
    parameter int unsigned STAGES      = 2
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   InValid,
    output logic                   InReady,
    input  logic [WIDTH-1:0]       A,
    input  logic [WIDTH-1:0]       B,
    input  logic                   Cin,
    input  logic                   Mode,
    output logic                   OutValid,
    input  logic                   OutReady,
`ifdef APPROX_ERR_STATS_EN
    input  logic                   StatsClr,
    output logic [STATS_SUM_W-1:0] ErrSum,
    output logic [STATS_CNT_W-1:0] ErrCnt,
    output logic [WIDTH:0]         ErrMax,
`endif
    output logic [WIDTH-1:0]       S,
    output logic                   Cout
);

    localparam int unsigned W = WIDTH / STAGES;

    logic [STAGES-1:0]            valid_vec, mode_vec, carry_vec, load_vec;
    logic [STAGES-1:0][WIDTH-1:0] a_vec, b_vec, sum_vec;
    logic [STAGES-1:0][WIDTH:0]   exact_vec;
    logic [WIDTH-1:0]             approx_mask;

    always_comb begin
        approx_mask = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            approx_mask[i] = (i < int'(APPROX_BITS));
        end
    end

    // A stage may load when it is empty or its contents move on this cycle.
    always_comb begin
        load_vec = '0;
        load_vec[STAGES-1] = !valid_vec[STAGES-1] || OutReady;
        for (int k = int'(STAGES) - 2; k >= 0; k--) begin
            load_vec[k] = !valid_vec[k] || load_vec[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             src_valid, src_mode, src_carry;
        logic [WIDTH-1:0] src_a, src_b, src_sum;
        logic [WIDTH:0]   src_exact;
        logic [W-1:0]     seg_sum;
        logic             seg_carry;
        logic [WIDTH-1:0] sum_d;
        logic             valid_q, mode_q, carry_q;
        logic [WIDTH-1:0] a_q, b_q, sum_q;
        logic [WIDTH:0]   exact_q;

        if (k == 0) begin : g_first
            assign src_valid = InValid;
            assign src_mode  = Mode;
            assign src_a     = A;
            assign src_b     = B;
            assign src_sum   = '0;
            assign src_carry = (Mode == MODE_EXACT || APPROX_BITS == 0) ? Cin : 1'b0;
            assign src_exact = (WIDTH+1)'(A) + (WIDTH+1)'(B) + (WIDTH+1)'(src_carry);
        end else begin : g_next
            assign src_valid = valid_vec[k-1];
            assign src_mode  = mode_vec[k-1];
            assign src_a     = a_vec[k-1];
            assign src_b     = b_vec[k-1];
            assign src_sum   = sum_vec[k-1];
            assign src_carry = carry_vec[k-1];
            assign src_exact = exact_vec[k-1];
        end

        approx_adder_segment #(
            .W (W)
        ) u_seg (
            .a_i      (src_a[k*W +: W]),
            .b_i      (src_b[k*W +: W]),
            .approx_i ((src_mode == MODE_APPROX) ? approx_mask[k*W +: W] : {W{1'b0}}),
            .carry_i  (src_carry),
            .sum_o    (seg_sum),
            .carry_o  (seg_carry)
        );

        always_comb begin
            sum_d = src_sum;
            sum_d[k*W +: W] = seg_sum;
        end

        always_ff @(posedge Clk) begin
            if (!Rst_n) begin
                valid_q <= 1'b0;
                mode_q  <= 1'b0;
                carry_q <= 1'b0;
                a_q     <= '0;
                b_q     <= '0;
                sum_q   <= '0;
                exact_q <= '0;
            end else if (load_vec[k]) begin
                valid_q <= src_valid;
                // Data only moves with a valid token so S holds its last value otherwise.
                if (src_valid) begin
                    mode_q  <= src_mode;
                    carry_q <= seg_carry;
                    a_q     <= src_a;
                    b_q     <= src_b;
                    sum_q   <= sum_d;
                    exact_q <= src_exact;
                end
            end
        end

        assign valid_vec[k] = valid_q;
        assign mode_vec[k]  = mode_q;
        assign carry_vec[k] = carry_q;
        assign a_vec[k]     = a_q;
        assign b_vec[k]     = b_q;
        assign sum_vec[k]   = sum_q;
        assign exact_vec[k] = exact_q;
    end

    assign InReady  = load_vec[0];
    assign OutValid = valid_vec[STAGES-1];
    assign S        = sum_vec[STAGES-1];
    assign Cout     = carry_vec[STAGES-1];

`ifdef APPROX_ERR_STATS_EN
    logic [WIDTH:0]         res, err;
    logic                   upd;
    logic [STATS_SUM_W:0]   sum_ext;
    logic [STATS_SUM_W-1:0] err_sum_d, err_sum_q;
    logic [STATS_CNT_W-1:0] err_cnt_d, err_cnt_q;
    logic [WIDTH:0]         err_max_d, err_max_q;

    assign res     = {carry_vec[STAGES-1], sum_vec[STAGES-1]};
    assign err     = (exact_vec[STAGES-1] >= res) ? exact_vec[STAGES-1] - res
                                                  : res - exact_vec[STAGES-1];
    assign upd     = valid_vec[STAGES-1] && OutReady && (mode_vec[STAGES-1] == MODE_APPROX);
    assign sum_ext = {1'b0, err_sum_q} + (STATS_SUM_W+1)'(err);

    always_comb begin
        err_sum_d = err_sum_q;
        err_cnt_d = err_cnt_q;
        err_max_d = err_max_q;
        if (upd) begin
            err_sum_d = sum_ext[STATS_SUM_W] ? '1 : sum_ext[STATS_SUM_W-1:0];
            if (err != '0 && err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
            if (err > err_max_q) begin
                err_max_d = err;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n || StatsClr) begin
            err_sum_q <= '0;
            err_cnt_q <= '0;
            err_max_q <= '0;
        end else begin
            err_sum_q <= err_sum_d;
            err_cnt_q <= err_cnt_d;
            err_max_q <= err_max_d;
        end
    end

    assign ErrSum = err_sum_q;
    assign ErrCnt = err_cnt_q;
    assign ErrMax = err_max_q;
`endif

    logic unused_vec;
    assign unused_vec = ^{a_vec, b_vec, mode_vec};

endmodule

// File: tb/tb_approx_pipe_adder.sv
// Directed self-checking bench for approx_pipe_adder (WIDTH=8, APPROX_BITS=2, STAGES=2).
module tb_approx_pipe_adder;

    logic       Clk = 1'b0;
    logic       Rst_n, InValid, InReady, Cin, Mode, OutValid, OutReady, Cout;
    logic [7:0] A, B, S;
`ifdef APPROX_ERR_STATS_EN
    logic        StatsClr;
    logic [31:0] ErrSum;
    logic [15:0] ErrCnt;
    logic [8:0]  ErrMax;
`endif

    int     n_cmp = 0;
    int     n_err = 0;
    longint m_sum = 0;
    int     m_cnt = 0;
    int     m_max = 0;

    always #5 Clk = ~Clk;

    approx_pipe_adder #(
        .WIDTH       (8),
        .APPROX_BITS (2),
        .STAGES      (2)
    ) dut (
        .Clk      (Clk),
        .Rst_n    (Rst_n),
        .InValid  (InValid),
        .InReady  (InReady),
        .A        (A),
        .B        (B),
        .Cin      (Cin),
        .Mode     (Mode),
        .OutValid (OutValid),
        .OutReady (OutReady),
`ifdef APPROX_ERR_STATS_EN
        .StatsClr (StatsClr),
        .ErrSum   (ErrSum),
        .ErrCnt   (ErrCnt),
        .ErrMax   (ErrMax),
`endif
        .S        (S),
        .Cout     (Cout)
    );

    // Reference: exact add, or OR on bits [1:0] with carry a[1]&b[1] into bit 2.
    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin, input logic m);
        logic [6:0] hi;
        logic       c;
        if (m) return {1'b0, a} + {1'b0, b} + {8'd0, cin};
        c  = a[1] & b[1];
        hi = {1'b0, a[7:2]} + {1'b0, b[7:2]} + {6'd0, c};
        return {hi, (a[1:0] | b[1:0])};
    endfunction

    task automatic gen_vec(input int i, input int pat, output logic [7:0] a,
                           output logic [7:0] b, output logic cin, output logic m);
        if (pat == 0) begin
            a   = i[7:0];
            b   = 8'(i * 37 + 11);
            cin = i[0];
            m   = i[1];
        end else begin
            a   = i[15:8];
            b   = i[7:0];
            cin = 1'b0;
            m   = 1'b0;
        end
    endtask

    // Presents one operand set, waits for its accept, then counts edges until OutValid.
    task automatic send_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                           input logic m, output int lat);
        InValid  = 1'b1;
        A        = a;
        B        = b;
        Cin      = cin;
        Mode     = m;
        OutReady = 1'b1;
        lat      = 0;
        while (!InReady && lat < 20) begin
            @(posedge Clk); #1;
            lat++;
        end
        @(posedge Clk); #1;
        InValid = 1'b0;
        lat = 0;
        while (!OutValid && lat < 20) begin
            @(posedge Clk); #1;
            lat++;
        end
    endtask

    task automatic run_stream(input int n, input int pat, input bit rand_ready,
                              input bit check_bubbles);
        int         sent = 0, got = 0, cyc = 0, first = -1, last = -1;
        bit         holding = 1'b0;
        logic [8:0] held, expv, ev, dv;
        logic [7:0] a, b;
        logic       cin, m;
        while (got < n && cyc < n * 4 + 100) begin
            if (sent < n) begin
                gen_vec(sent, pat, a, b, cin, m);
                InValid = 1'b1;
                A = a; B = b; Cin = cin; Mode = m;
            end else begin
                InValid = 1'b0;
            end
            OutReady = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge Clk);
            if (holding) begin
                n_cmp++;
                if (!OutValid || {Cout, S} !== held)
                    $display("FAIL stall_hold: got valid=%b sum=%h, want valid=1 sum=%h",
                             OutValid, {Cout, S}, held);
                if (!OutValid || {Cout, S} !== held) n_err++;
            end
            holding = OutValid && !OutReady;
            held    = {Cout, S};
            if (OutValid && OutReady) begin
                gen_vec(got, pat, a, b, cin, m);
                expv = model(a, b, cin, m);
                n_cmp++;
                if ({Cout, S} !== expv) begin
                    n_err++;
                    $display("FAIL stream_result[%0d]: got %h, want %h (a=%h b=%h cin=%b m=%b)",
                             got, {Cout, S}, expv, a, b, cin, m);
                end
                if (pat == 1) begin
                    ev = {1'b0, a} + {1'b0, b};
                    dv = (ev >= expv) ? ev - expv : expv - ev;
                    m_sum += longint'(dv);
                    if (dv != 0 && m_cnt < 65535) m_cnt++;
                    if (int'(dv) > m_max) m_max = int'(dv);
                end
                if (first < 0) first = cyc;
                last = cyc;
                got++;
            end
            if (InValid && InReady) sent++;
            @(posedge Clk); #1;
            cyc++;
        end
        InValid  = 1'b0;
        OutReady = 1'b1;
        n_cmp++;
        if (got != n) begin
            n_err++;
            $display("FAIL stream_count: got %0d results, want %0d", got, n);
        end
        if (check_bubbles) begin
            n_cmp++;
            if (last - first + 1 != n) begin
                n_err++;
                $display("FAIL stream_bubbles: span %0d cycles, want %0d", last - first + 1, n);
            end
        end
        repeat (3) begin
            n_cmp++;
            if (OutValid !== 1'b0) begin
                n_err++;
                $display("FAIL stream_dup: got OutValid=%b after drain, want 0", OutValid);
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; InValid = 1'b1; A = 8'h5a; B = 8'h33; Cin = 1'b1; Mode = 1'b1;
        OutReady = 1'b1;
`ifdef APPROX_ERR_STATS_EN
        StatsClr = 1'b0;
`endif
        repeat (2) @(posedge Clk);
        #1;
        n_cmp += 3;
        if (OutValid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, want 0", OutValid); end
        if (S !== 8'h00) begin n_err++; $display("FAIL reset_s: got %h, want 00", S); end
        if (Cout !== 1'b0) begin n_err++; $display("FAIL reset_cout: got %b, want 0", Cout); end
        Rst_n = 1'b1;
        InValid = 1'b0;
        #1;
        n_cmp++;
        if (InReady !== 1'b1) begin n_err++; $display("FAIL reset_inready: got %b, want 1", InReady); end
        @(posedge Clk); #1;
    endtask

    task automatic test_approx();
        int lat;
        send_op(8'd3, 8'd1, 1'b0, 1'b0, lat);
        n_cmp += 2;
        if (lat !== 1) begin n_err++; $display("FAIL approx_latency: got %0d, want 1", lat); end
        if ({Cout, S} !== 9'h003) begin n_err++; $display("FAIL approx_3_1: got %h, want 003", {Cout, S}); end
        send_op(8'd255, 8'd1, 1'b0, 1'b0, lat);
        n_cmp++;
        if ({Cout, S} !== 9'h0FF) begin n_err++; $display("FAIL approx_255_1: got %h, want 0ff", {Cout, S}); end
        send_op(8'd3, 8'd1, 1'b1, 1'b0, lat);
        n_cmp++;
        if ({Cout, S} !== 9'h003) begin n_err++; $display("FAIL approx_cin_ignored: got %h, want 003", {Cout, S}); end
        send_op(8'd2, 8'd2, 1'b0, 1'b0, lat);
        n_cmp++;
        if ({Cout, S} !== 9'h006) begin n_err++; $display("FAIL approx_2_2: got %h, want 006", {Cout, S}); end
        send_op(8'd255, 8'd255, 1'b1, 1'b0, lat);
        n_cmp++;
        if ({Cout, S} !== 9'h1FF) begin n_err++; $display("FAIL approx_255_255: got %h, want 1ff", {Cout, S}); end
    endtask

    task automatic test_exact();
        int lat;
        send_op(8'd3, 8'd1, 1'b0, 1'b1, lat);
        n_cmp += 2;
        if (lat !== 1) begin n_err++; $display("FAIL exact_latency: got %0d, want 1", lat); end
        if ({Cout, S} !== 9'h004) begin n_err++; $display("FAIL exact_3_1: got %h, want 004", {Cout, S}); end
        send_op(8'd255, 8'd1, 1'b0, 1'b1, lat);
        n_cmp++;
        if ({Cout, S} !== 9'h100) begin n_err++; $display("FAIL exact_255_1: got %h, want 100", {Cout, S}); end
        send_op(8'd255, 8'd255, 1'b1, 1'b1, lat);
        n_cmp++;
        if ({Cout, S} !== 9'h1FF) begin n_err++; $display("FAIL exact_255_255_1: got %h, want 1ff", {Cout, S}); end
        send_op(8'd0, 8'd0, 1'b1, 1'b1, lat);
        n_cmp++;
        if ({Cout, S} !== 9'h001) begin n_err++; $display("FAIL exact_cin_only: got %h, want 001", {Cout, S}); end
        @(posedge Clk); #1;
    endtask

    task automatic test_back_to_back();
        run_stream(256, 0, 1'b0, 1'b1);
    endtask

    task automatic test_stall();
        run_stream(64, 0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_midflight();
        int lat;
        OutReady = 1'b0;
        InValid = 1'b1; A = 8'd10; B = 8'd20; Cin = 1'b0; Mode = 1'b1;
        @(posedge Clk); #1;
        A = 8'd30; B = 8'd40;
        @(posedge Clk); #1;
        InValid = 1'b0;
        n_cmp += 2;
        if (OutValid !== 1'b1) begin n_err++; $display("FAIL midflight_full: got OutValid=%b, want 1", OutValid); end
        if (InReady !== 1'b0) begin n_err++; $display("FAIL midflight_stall: got InReady=%b, want 0", InReady); end
        Rst_n = 1'b0;
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        OutReady = 1'b1;
        repeat (4) begin
            n_cmp++;
            if (OutValid !== 1'b0) begin n_err++; $display("FAIL midflight_flush: got OutValid=%b, want 0", OutValid); end
            @(posedge Clk); #1;
        end
        send_op(8'd100, 8'd27, 1'b1, 1'b1, lat);
        n_cmp++;
        if ({Cout, S} !== 9'h080) begin n_err++; $display("FAIL midflight_next: got %h, want 080", {Cout, S}); end
        @(posedge Clk); #1;
    endtask

`ifdef APPROX_ERR_STATS_EN
    task automatic test_stats();
        StatsClr = 1'b1;
        @(posedge Clk); #1;
        StatsClr = 1'b0;
        m_sum = 0; m_cnt = 0; m_max = 0;
        run_stream(65536, 1, 1'b0, 1'b1);
        n_cmp += 3;
        if (ErrMax !== 9'(m_max)) begin n_err++; $display("FAIL stats_max: got %0d, want %0d", ErrMax, m_max); end
        if (ErrCnt !== 16'(m_cnt)) begin n_err++; $display("FAIL stats_cnt: got %0d, want %0d", ErrCnt, m_cnt); end
        if (ErrSum !== 32'(m_sum)) begin n_err++; $display("FAIL stats_sum: got %0d, want %0d", ErrSum, m_sum); end
        StatsClr = 1'b1;
        @(posedge Clk); #1;
        StatsClr = 1'b0;
        n_cmp++;
        if (ErrSum !== 32'd0 || ErrCnt !== 16'd0 || ErrMax !== 9'd0) begin
            n_err++;
            $display("FAIL stats_clear: got sum=%0d cnt=%0d max=%0d, want 0 0 0", ErrSum, ErrCnt, ErrMax);
        end
    endtask
`endif

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_approx();
        test_exact();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
`ifdef APPROX_ERR_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
